sdf_output_reorder: RTL and testbench
=====================================

Name: sdf_output_reorder

Overview:
- Sits directly downstream of the last SDF NTT/INTT stage.
- Captures the stage's one-coefficient-per-cycle output stream (finish/stage_out), which arrives in bit-reversed order.
- Uses a ping-pong pair of N-entry buffers to restore natural order.
- Presents the result on a valid/ready stream to the consumer (memory writer / host DMA). One buffer fills while the other drains.

Parameters:
- LOGQ, 64, coefficient width in bits.
- LOGN, 10, log2 of polynomial length; N = 2**LOGN.
- BITREV, 1, 1: write address is bit-reverse of write index; 0: natural write address (pure double buffer).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- in_valid  input  1  one coefficient present (driven by SDF stage finish).
- in_data  input  LOGQ  coefficient (driven by SDF stage stage_out).
- out_valid  output  1  out_data holds a valid coefficient.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  LOGQ  coefficient, natural order.
- out_last  output  1  marks coefficient index N-1 of a frame.
- busy  output  1  at least one bank full or a frame partially written.
- overflow  output  1  sticky: an input sample was dropped.

Behaviour:
- Reset: when rst==0 at a clock edge, the following are cleared on that edge:
  - wr_cnt=0, wr_bank=0, rd_cnt=0, rd_bank=0, full[1:0]=0;
  - out_valid=0, out_last=0, out_data=0, overflow=0, busy=0.
  - Buffer contents are don't-care. Asserting reset mid-frame discards all partial and full frames.
- Storage: two banks of N x LOGQ, inferred RAM with 1-cycle registered read. Bank RAM needs no reset.
- Write side (no backpressure to SDF pipeline):
  - If in_valid && !full[wr_bank]: write in_data to bank wr_bank at address bitrev_LOGN(wr_cnt) (or wr_cnt when BITREV=0), then wr_cnt++.
  - When the write with wr_cnt==N-1 occurs: set full[wr_bank], toggle wr_bank, wr_cnt wraps to 0.
  - If in_valid && full[wr_bank]: sample dropped, wr_cnt unchanged, overflow<=1 (sticky until reset).
- Read side FSM:
  - IDLE: wait for full[rd_bank]; then issue RAM read of address 0 and go to PRIME.
  - PRIME: RAM data lands in the output register; out_valid<=1; go to STREAM.
  - STREAM: on handshake (out_valid && out_ready):
    - rd_cnt++;
    - if rd_cnt was not N-1, read the next address, keeping out_valid=1 continuously (prefetch so throughput is 1/cycle);
    - if rd_cnt was N-1: clear full[rd_bank], toggle rd_bank, rd_cnt=0;
      - if the other bank is already full, continue streaming with no bubble;
      - else out_valid<=0 and return to IDLE.
- out_data and out_last are held stable while out_valid && !out_ready.
- out_last=1 exactly when the presented coefficient has index N-1.
- Latency: first out_valid rises 2 cycles after the clock edge that accepts the N-th sample of a frame into an empty read path.
- Simultaneous events:
  - A set of full[] by the writer and a clear by the reader in the same cycle always target different banks; both take effect.
  - A write into a bank in the same cycle the reader clears that bank's full flag is impossible; at that point the writer is already on the opposite bank.
- busy = full[0] | full[1] | (wr_cnt!=0) | out_valid.

Optional Feature:
- Macro: SDF_REORDER_DROP_COUNT_EN.
- Defined: adds output port drop_count [15:0]. It increments by 1 on each dropped sample, saturates at 16'hFFFF, and resets to 0.
- Undefined: no port and no counter. overflow alone reports drops.

Test Plan:
- LOGN=3, BITREV=1, feed in_data=0..7 on 8 consecutive cycles, out_ready=1:
  - outputs are 0,4,2,6,1,5,3,7;
  - out_last on the 8th output only;
  - first out_valid 2 cycles after the 8th input edge.
- Two back-to-back frames (0..7, 8..15), out_ready=1:
  - 16 contiguous outputs 0,4,2,6,1,5,3,7,8,12,10,14,9,13,11,15 with no out_valid gap between frames.
- One frame with out_ready pattern 1,0,1,0…:
  - every output is held stable while stalled;
  - exactly 8 handshakes, no duplicates or losses.
- out_ready=0, feed 24 samples (values 0..23):
  - overflow rises the cycle after sample 16 (value 16) and stays high;
  - after out_ready=1, the 16 outputs are frames 0..7 and 8..15 reordered; values 16..23 never appear.
- After 5 samples of a frame, drive rst=0 for one cycle:
  - out_valid=0, busy=0, overflow=0;
  - a following full frame 0..7 reorders correctly.
- LOGN=3, BITREV=0, feed 0..7:
  - outputs 0..7 in order;
  - with SDF_REORDER_DROP_COUNT_EN defined, drop_count==8 after the 24-sample overflow scenario.

Source files
------------

// File: rtl/sdf_output_reorder.sv
// Ping-pong bit-reverse reorder buffer behind the last SDF NTT/INTT stage; natural-order valid/ready output.
// Optional SDF_REORDER_DROP_COUNT_EN adds a saturating drop_count[15:0] port.
module sdf_output_reorder #(
  parameter int LOGQ   = 64,
  parameter int LOGN   = 10,
  parameter int BITREV = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [LOGQ-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGQ-1:0] out_data,
  output logic            out_last,
  output logic            busy,
  output logic            overflow
`ifdef SDF_REORDER_DROP_COUNT_EN
  ,output logic [15:0]    drop_count
`endif
);

  localparam int N = 1 << LOGN;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] PRIME  = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;

  logic [LOGQ-1:0] mem [2][N];

  logic [1:0]      state;
  logic [LOGN-1:0] wr_cnt;
  logic [LOGN-1:0] rd_cnt;
  logic            wr_bank;
  logic            rd_bank;
  logic [1:0]      full;
  logic [1:0]      full_n;

  logic            wr_en;
  logic            wr_done;
  logic            drop;
  logic [LOGN-1:0] wr_addr;

  logic            hs;
  logic            rd_last;
  logic            rd_en;
  logic            rd_sel;
  logic            rd_done;
  logic [LOGN-1:0] rd_addr;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
    logic [LOGN-1:0] r;
    for (int unsigned i = 0; i < LOGN; i++) r[i] = a[LOGN-1-i];
    return r;
  endfunction

  assign wr_en   = in_valid && !full[wr_bank];
  assign drop    = in_valid && full[wr_bank];
  assign wr_done = wr_en && (wr_cnt == '1);
  assign wr_addr = (BITREV != 0) ? bitrev(wr_cnt) : wr_cnt;

  assign hs      = out_valid && out_ready;
  assign rd_last = (rd_cnt == '1);

  // The RAM's registered read port is the output register itself; PRIME
  // only delays out_valid by the read latency of the first coefficient.
  always_comb begin
    rd_en   = 1'b0;
    rd_sel  = rd_bank;
    rd_addr = rd_cnt + 1'b1;
    rd_done = 1'b0;
    case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          rd_en   = 1'b1;
          rd_addr = '0;
        end
      end
      STREAM: begin
        if (hs) begin
          if (!rd_last) begin
            rd_en = 1'b1;
          end else begin
            rd_done = 1'b1;
            if (full[!rd_bank]) begin
              rd_en   = 1'b1;
              rd_sel  = !rd_bank;
              rd_addr = '0;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Writer sets and reader clears always target different banks.
  always_comb begin
    full_n = full;
    if (wr_done) full_n[wr_bank] = 1'b1;
    if (rd_done) full_n[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_addr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      wr_cnt    <= '0;
      wr_bank   <= 1'b0;
      rd_cnt    <= '0;
      rd_bank   <= 1'b0;
      full      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_done) wr_bank <= !wr_bank;
      end
      if (drop) overflow <= 1'b1;
      full <= full_n;

      if (rd_en) begin
        out_data <= mem[rd_sel][rd_addr];
        out_last <= (rd_addr == '1);
      end

      case (state)
        IDLE: begin
          if (full[rd_bank]) state <= PRIME;
        end
        PRIME: begin
          out_valid <= 1'b1;
          state     <= STREAM;
        end
        STREAM: begin
          if (hs) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (rd_last) begin
              rd_bank <= !rd_bank;
              if (!full[!rd_bank]) begin
                out_valid <= 1'b0;
                state     <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = full[0] | full[1] | (wr_cnt != '0) | out_valid;

`ifdef SDF_REORDER_DROP_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst)
      drop_count <= '0;
    else if (drop && (drop_count != '1))
      drop_count <= drop_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_sdf_output_reorder.sv
// Scoreboard bench: BITREV=1 and BITREV=0 instances share stimulus, each checked against its own expected queue.
module tb_sdf_output_reorder;
  localparam int LOGQ = 16;
  localparam int LOGN = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic [LOGQ-1:0] in_data = '0;
  logic            out_ready = 1'b0;

  logic            ov1, ol1, b1, of1;
  logic [LOGQ-1:0] od1;
  logic            ov2, ol2, b2, of2;
  logic [LOGQ-1:0] od2;
`ifdef SDF_REORDER_DROP_COUNT_EN
  logic [15:0]     dc1, dc2;
`endif

  sdf_output_reorder #(.LOGQ(LOGQ), .LOGN(LOGN), .BITREV(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_last(ol1),
    .busy(b1), .overflow(of1)
`ifdef SDF_REORDER_DROP_COUNT_EN
    , .drop_count(dc1)
`endif
  );

  sdf_output_reorder #(.LOGQ(LOGQ), .LOGN(LOGN), .BITREV(0)) dut_nat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_last(ol2),
    .busy(b2), .overflow(of2)
`ifdef SDF_REORDER_DROP_COUNT_EN
    , .drop_count(dc2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LOGQ-1:0] d;
    logic            l;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   hs_cyc[$];
  int   ncmp = 0;
  int   nfail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor for the bit-reversing instance, including hold-while-stalled checks.
  logic            stalled = 1'b0;
  logic [LOGQ-1:0] hd;
  logic            hl;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("hold_valid", 64'(ov1), 64'd1);
        check("hold_data", 64'(od1), 64'(hd));
        check("hold_last", 64'(ol1), 64'(hl));
      end
      if (ov1 && out_ready) begin
        hs_cyc.push_back(cyc);
        ncmp++;
        assert (q1.size() > 0) else begin
          nfail++;
          $error("FAIL spurious_out1: observed data %0h expected no output", od1);
        end
        if (q1.size() > 0) begin
          e = q1.pop_front();
          check("out1_data", 64'(od1), 64'(e.d));
          check("out1_last", 64'(ol1), 64'(e.l));
        end
      end
      stalled = ov1 && !out_ready;
      hd = od1;
      hl = ol1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst && ov2 && out_ready) begin
      ncmp++;
      assert (q2.size() > 0) else begin
        nfail++;
        $error("FAIL spurious_out2: observed data %0h expected no output", od2);
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        check("out2_data", 64'(od2), 64'(e.d));
        check("out2_last", 64'(ol2), 64'(e.l));
      end
    end
  end

  task automatic feed(input int first, input int count);
    for (int i = 0; i < count; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = LOGQ'(first + i);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_frame(input int base);
    int br[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.d = LOGQ'(base + br[k]);
      e.l = (k == 7);
      q1.push_back(e);
      e.d = LOGQ'(base + k);
      q2.push_back(e);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    check(tag, 64'(q1.size() + q2.size()), 64'd0);
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(ov1), 64'd0);
    check("rst_out_last", 64'(ol1), 64'd0);
    check("rst_out_data", 64'(od1), 64'd0);
    check("rst_busy", 64'(b1), 64'd0);
    check("rst_overflow", 64'(of1), 64'd0);
    check("rst_out_valid_nat", 64'(ov2), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Single frame, latency of first out_valid
    out_ready = 1'b1;
    expect_frame(0);
    feed(0, 8);
    @(negedge clk);
    check("lat_edge0", 64'(ov1), 64'd0);
    check("busy_full", 64'(b1), 64'd1);
    @(negedge clk);
    check("lat_edge1", 64'(ov1), 64'd0);
    @(negedge clk);
    check("lat_edge2", 64'(ov1), 64'd1);
    drain("drain_single", 50);
    @(posedge clk);
    #1;
    check("busy_idle", 64'(b1), 64'd0);

    // Two back-to-back frames, no gap between them
    hs_cyc.delete();
    expect_frame(0);
    expect_frame(8);
    feed(0, 16);
    drain("drain_b2b", 60);
    check("b2b_count", 64'(hs_cyc.size()), 64'd16);
    if (hs_cyc.size() == 16)
      check("b2b_contiguous", 64'(hs_cyc[15] - hs_cyc[0]), 64'd15);

    // Alternating out_ready
    out_ready = 1'b0;
    hs_cyc.delete();
    expect_frame(0);
    feed(0, 8);
    for (int i = 0; i < 100 && (q1.size() != 0 || q2.size() != 0); i++) begin
      @(posedge clk);
      #1;
      out_ready = (i % 2 == 0);
    end
    drain("drain_stall", 10);
    check("stall_count", 64'(hs_cyc.size()), 64'd8);
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Overflow: both banks full, excess samples dropped
    expect_frame(0);
    expect_frame(8);
    feed(0, 16);
    @(negedge clk);
    check("ovf_before", 64'(of1), 64'd0);
    feed(16, 1);
    @(negedge clk);
    check("ovf_rise", 64'(of1), 64'd1);
    feed(17, 7);
    @(negedge clk);
    check("ovf_sticky", 64'(of1), 64'd1);
    check("ovf_sticky_nat", 64'(of2), 64'd1);
`ifdef SDF_REORDER_DROP_COUNT_EN
    check("drop_count", 64'(dc1), 64'd8);
    check("drop_count_nat", 64'(dc2), 64'd8);
`endif
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain("drain_ovf", 100);
    @(posedge clk);
    #1;

    // Reset in the middle of a frame
    feed(0, 5);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 64'(ov1), 64'd0);
    check("midrst_busy", 64'(b1), 64'd0);
    check("midrst_overflow", 64'(of1), 64'd0);
`ifdef SDF_REORDER_DROP_COUNT_EN
    check("midrst_drop_count", 64'(dc1), 64'd0);
`endif
    rst = 1'b1;
    expect_frame(0);
    feed(0, 8);
    drain("drain_after_rst", 50);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
